dwc_axil_reg_slave: RTL and testbench
=====================================

DWC_AXIL_REG_SLAVE -- requirements
Module: dwc_axil_reg_slave

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 6, byte address width; minimum 4.
REQ-003 s00_axi_aclk  in  1  the only clock; all logic is rising-edge.
REQ-004 s00_axi_areset  in  1  reset, synchronous, active-high.
REQ-005 s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address; s00_axi_awprot  in  3  ignored.
REQ-006 s00_axi_awvalid  in  1 / s00_axi_awready  out  1  AW handshake.
REQ-007 s00_axi_wdata  in  32 / s00_axi_wstrb  in  4  write data and byte strobes.
REQ-008 s00_axi_wvalid  in  1 / s00_axi_wready  out  1  W handshake.
REQ-009 s00_axi_bresp  out  2 / s00_axi_bvalid  out  1 / s00_axi_bready  in  1  B channel.
REQ-010 s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH / s00_axi_arprot  in  3 (ignored) / s00_axi_arvalid  in  1 / s00_axi_arready  out  1  AR channel.
REQ-011 s00_axi_rdata  out  32 / s00_axi_rresp  out  2 / s00_axi_rvalid  out  1 / s00_axi_rready  in  1  R channel.
REQ-012 reg_out  out  128  live register contents, {reg3,reg2,reg1,reg0}, for fabric use.

Function
REQ-013 Four 32-bit registers reg0..reg3 SHALL be mapped at byte offsets 0x0, 0x4, 0x8 and 0xC.
REQ-014 Decode: addr[1:0] ignored; addr[3:2] selects the register; any nonzero addr[C_S_AXI_ADDR_WIDTH-1:4] is out of range.
REQ-015 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-016 W_IDLE: awready=1, wready=1. AW-only handshake -> W_HAVE_AW (awready=0, wready=1). W-only handshake -> W_HAVE_W (awready=1, wready=0). Both in one cycle -> commit.
REQ-017 Commit occurs on the edge that completes the last of the AW/W handshakes. On that edge the register updates, bvalid rises, and the FSM enters W_RESP with awready=0 and wready=0.
REQ-018 Register update latency: a value written by a handshake in cycle N is visible on reg_out and to reads accepted from cycle N+1.
REQ-019 W_RESP: bvalid and bresp are held until bvalid&&bready, then -> W_IDLE. bvalid=1 and bready=1 in the same cycle is one completed handshake.
REQ-020 Out-of-range write: no register changes; bresp=2'b10 (SLVERR). In-range write: bresp=2'b00.
REQ-021 Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
REQ-022 On arvalid&&arready in cycle N, rdata and rresp are registered and rvalid=1 in cycle N+1; they are held stable until rvalid&&rready, then -> R_IDLE.
REQ-023 Out-of-range read: rdata=0, rresp=2'b10. In-range read: rresp=2'b00.
REQ-024 Read and write channels SHALL operate independently and concurrently; at most one outstanding transaction per direction.
REQ-025 Read accepted in the same cycle as a commit to the same register returns the pre-write value.
REQ-026 No combinational path from any input to any ready or valid output.

Reset
REQ-027 While s00_axi_areset=1 at a rising edge: both FSMs go to idle; reg0..reg3=0; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-028 The ready outputs SHALL be 0 while reset is asserted and SHALL take idle values the first cycle after deassertion.
REQ-029 Reset mid-transaction SHALL abandon any captured AW/W and pending B/R without completing the write.

Configuration
REQ-030 Macro DWC_AXIL_WSTRB_EN defined: only bytes with wstrb[k]=1 are written (bits 8k+7:8k).
REQ-031 Macro DWC_AXIL_WSTRB_EN undefined: wstrb is ignored and the full 32-bit word is written.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read the same addresses -> reads return 0x1..0x4, all resp=00, reg_out=0x00000004_00000003_00000002_00000001.
REQ-033 AW at 0x8 in cycle 10, W 0xCAFEF00D in cycle 14, bready=1 -> awready=0 in cycles 11-14, bvalid=1 in cycle 15, reg2=0xCAFEF00D from cycle 15.
REQ-034 With DWC_AXIL_WSTRB_EN: reg1=0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> reg1=0x11BB33DD. Without the macro -> reg1=0xAABBCCDD.
REQ-035 Write to 0x10 and read of 0x20 -> bresp=10 with registers unchanged; rresp=10 with rdata=0.
REQ-036 Hold bready=0 and rready=0 for 5 cycles after the handshakes -> bvalid, rvalid, rdata and bresp stay stable, and awready, wready and arready stay 0 throughout.
REQ-037 Assert reset while in W_HAVE_AW (awaddr 0x4), then issue W 0x55 -> reg1 stays 0 and no bvalid is generated for the abandoned transaction.

Source files
------------

// File: rtl/dwc_axil_reg_slave_if.sv
// AXI4-Lite bus bundle for dwc_axil_reg_slave.
// The master modport drives addresses, data and the response-ready signals;
// the slave modport drives the address/data ready signals and the responses.
interface dwc_axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s00_axi_awaddr;
    logic [2:0]              s00_axi_awprot;
    logic                    s00_axi_awvalid;
    logic                    s00_axi_awready;
    logic [DATA_WIDTH-1:0]   s00_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s00_axi_wstrb;
    logic                    s00_axi_wvalid;
    logic                    s00_axi_wready;
    logic [1:0]              s00_axi_bresp;
    logic                    s00_axi_bvalid;
    logic                    s00_axi_bready;
    logic [ADDR_WIDTH-1:0]   s00_axi_araddr;
    logic [2:0]              s00_axi_arprot;
    logic                    s00_axi_arvalid;
    logic                    s00_axi_arready;
    logic [DATA_WIDTH-1:0]   s00_axi_rdata;
    logic [1:0]              s00_axi_rresp;
    logic                    s00_axi_rvalid;
    logic                    s00_axi_rready;

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_rready,
        input  s00_axi_awready, s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_rready,
        output s00_axi_awready, s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
    );
endinterface

// File: rtl/dwc_axil_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit registers at byte offsets 0x0..0xC.
// Addresses with any bit set above bit 3 answer SLVERR and touch nothing.
// Optional macro DWC_AXIL_WSTRB_EN: honour wstrb byte lanes on writes;
// without it every write replaces the whole word.
//
// Handshake rule: a transfer happens on the rising edge where valid and ready
// are both 1. Every ready/valid output here is decoded from registered state
// only, so no input reaches them combinationally.
module dwc_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_areset,
    dwc_axil_reg_slave_if.slave  s_axi,
    output logic [127:0]         reg_out
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic                          live;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wd_q;
    logic [SW-1:0]                 ws_q;

    logic                          aw_hs, w_hs, ar_hs;
    logic                          commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] c_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] c_data;
    logic [SW-1:0]                 c_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] c_word;
    logic                          w_oor, r_oor;

    // Held low through reset so every ready output reads 0 until the first
    // edge after reset is released.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) live <= 1'b0;
        else                live <= 1'b1;
    end

    assign s_axi.s00_axi_awready = live && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign s_axi.s00_axi_wready  = live && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign s_axi.s00_axi_bvalid  = (w_state == W_RESP);
    assign s_axi.s00_axi_arready = live && (r_state == R_IDLE);
    assign s_axi.s00_axi_rvalid  = (r_state == R_DATA);

    assign aw_hs = s_axi.s00_axi_awvalid && s_axi.s00_axi_awready;
    assign w_hs  = s_axi.s00_axi_wvalid  && s_axi.s00_axi_wready;
    assign ar_hs = s_axi.s00_axi_arvalid && s_axi.s00_axi_arready;

    // Write FSM next state; picks live or captured AW/W fields for the commit.
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        c_addr = s_axi.s00_axi_awaddr;
        c_data = s_axi.s00_axi_wdata;
        c_strb = s_axi.s00_axi_wstrb;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                c_addr = aw_q;
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                c_data = wd_q;
                c_strb = ws_q;
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.s00_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_oor = |(c_addr >> 4);
    assign r_oor = |(s_axi.s00_axi_araddr >> 4);

    // New register word: byte-merged with the old value or a full replace.
    always_comb begin
        c_word = c_data;
`ifdef DWC_AXIL_WSTRB_EN
        for (int k = 0; k < SW; k++) begin
            if (!c_strb[k]) c_word[8*k +: 8] = regs[c_addr[3:2]][8*k +: 8];
        end
`endif
    end

    // Write FSM state, AW/W capture, register file and B response.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state             <= W_IDLE;
            aw_q                <= '0;
            wd_q                <= '0;
            ws_q                <= '0;
            s_axi.s00_axi_bresp <= 2'b00;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) aw_q <= s_axi.s00_axi_awaddr;
            if (w_hs) begin
                wd_q <= s_axi.s00_axi_wdata;
                ws_q <= s_axi.s00_axi_wstrb;
            end
            if (commit) begin
                s_axi.s00_axi_bresp <= w_oor ? 2'b10 : 2'b00;
                if (!w_oor) regs[c_addr[3:2]] <= c_word;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s_axi.s00_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state and registered read data; sees pre-commit register values.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state             <= R_IDLE;
            s_axi.s00_axi_rdata <= '0;
            s_axi.s00_axi_rresp <= 2'b00;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                s_axi.s00_axi_rdata <= r_oor ? '0 : regs[s_axi.s00_axi_araddr[3:2]];
                s_axi.s00_axi_rresp <= r_oor ? 2'b10 : 2'b00;
            end
        end
    end

    assign reg_out = {regs[3], regs[2], regs[1], regs[0]};

    // Protection bits, sub-word address bits and (without byte-lane support)
    // the strobes carry no meaning for this register block.
    logic unused_bits;
    assign unused_bits = ^{s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                           s_axi.s00_axi_araddr[1:0], c_addr[1:0], c_strb};
endmodule

// File: tb/tb_dwc_axil_reg_slave.sv
// Bench for dwc_axil_reg_slave: directed scenarios plus randomized traffic,
// checked against a word-level register model kept here.
module tb_dwc_axil_reg_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [127:0] reg_out;

    dwc_axil_reg_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    dwc_axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s_axi          (bus.slave),
        .reg_out        (reg_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef DWC_AXIL_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [31:0] mdl [4];

    function automatic bit in_range(input logic [5:0] a);
        return a < 6'd16;
    endfunction

    function automatic logic [127:0] mdl_vec();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int k = 0; k < 4; k++)
                if (!STRB_EN || s[k]) mdl[a / 4][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.s00_axi_awaddr  = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata   = '0; bus.s00_axi_wstrb  = '0; bus.s00_axi_wvalid  = 1'b0;
        bus.s00_axi_bready  = 1'b0;
        bus.s00_axi_araddr  = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_awready", bus.s00_axi_awready, 0);
        check("rst_wready",  bus.s00_axi_wready,  0);
        check("rst_arready", bus.s00_axi_arready, 0);
        check("rst_bvalid",  bus.s00_axi_bvalid,  0);
        check("rst_rvalid",  bus.s00_axi_rvalid,  0);
        check("rst_resp",    {bus.s00_axi_bresp, bus.s00_axi_rresp}, 0);
        check("rst_rdata",   bus.s00_axi_rdata,   0);
        check("rst_reg_out", reg_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_readys",
              {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 3'b111);
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        @(posedge clk); #1;
    endtask

    // Full write with independent AW/W start delays; bready held high.
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        bus.s00_axi_awaddr = a;
        bus.s00_axi_wdata  = d;
        bus.s00_axi_wstrb  = s;
        bus.s00_axi_bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.s00_axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s00_axi_wvalid  = !w_done  && (cyc >= w_dly);
            @(negedge clk);
            aw_fire = bus.s00_axi_awvalid && bus.s00_axi_awready;
            w_fire  = bus.s00_axi_wvalid  && bus.s00_axi_wready;
            @(posedge clk); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            cyc++;
        end
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        check("wr_handshakes", {aw_done, w_done}, 2'b11);
        model_write(a, d, s);
        @(negedge clk);
        check("wr_b_latency", bus.s00_axi_bvalid, 1);
        check("wr_bresp", bus.s00_axi_bresp, in_range(a) ? 2'b00 : 2'b10);
        check("wr_reg_out", reg_out, mdl_vec());
        @(posedge clk); #1;
        bus.s00_axi_bready = 1'b0;
        @(negedge clk);
        check("wr_back_idle", {bus.s00_axi_bvalid, bus.s00_axi_awready}, 2'b01);
        @(posedge clk); #1;
    endtask

    // Full read with an AR start delay; rready held high.
    task automatic axi_read(input logic [5:0] a, input int ar_dly);
        bit ar_done = 0, ar_fire;
        int cyc = 0;
        logic [31:0] exp_d;
        bus.s00_axi_araddr = a;
        bus.s00_axi_rready = 1'b1;
        while (!ar_done && cyc < 50) begin
            bus.s00_axi_arvalid = (cyc >= ar_dly);
            @(negedge clk);
            ar_fire = bus.s00_axi_arvalid && bus.s00_axi_arready;
            @(posedge clk); #1;
            if (ar_fire) ar_done = 1;
            cyc++;
        end
        bus.s00_axi_arvalid = 1'b0;
        check("rd_handshake", ar_done, 1);
        exp_d = in_range(a) ? mdl[a / 4] : 32'h0;
        @(negedge clk);
        check("rd_rvalid", bus.s00_axi_rvalid, 1);
        check("rd_rdata", bus.s00_axi_rdata, exp_d);
        check("rd_rresp", bus.s00_axi_rresp, in_range(a) ? 2'b00 : 2'b10);
        @(posedge clk); #1;
        bus.s00_axi_rready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d, exp_r;
        logic [5:0]  a;
        logic [3:0]  s;

        idle_inputs();
        do_reset();

        // Four writes then four reads of the same offsets.
        for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(6'(4 * i), 0);
        check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

        // AW early, W four cycles later.
        bus.s00_axi_awaddr = 6'h8; bus.s00_axi_awvalid = 1'b1; bus.s00_axi_bready = 1'b1;
        @(negedge clk);
        check("split_aw_ready", bus.s00_axi_awready, 1);
        @(posedge clk); #1;
        bus.s00_axi_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("split_aw_blocked", {bus.s00_axi_awready, bus.s00_axi_bvalid}, 2'b00);
            @(posedge clk); #1;
        end
        bus.s00_axi_wdata = 32'hCAFEF00D; bus.s00_axi_wstrb = 4'hF; bus.s00_axi_wvalid = 1'b1;
        @(negedge clk);
        check("split_w_cycle", {bus.s00_axi_awready, bus.s00_axi_wready}, 2'b01);
        @(posedge clk); #1;
        bus.s00_axi_wvalid = 1'b0;
        model_write(6'h8, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        check("split_bvalid", {bus.s00_axi_bvalid, bus.s00_axi_bresp}, 3'b100);
        check("split_reg2", reg_out[95:64], 32'hCAFEF00D);
        @(posedge clk); #1;
        bus.s00_axi_bready = 1'b0;

        // Byte strobes.
        axi_write(6'h4, 32'h11223344, 4'hF, 1, 0);
        axi_write(6'h4, 32'hAABBCCDD, 4'b0101, 0, 2);
        check("strb_reg1", reg_out[63:32], STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD);

        // Out-of-range accesses.
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(6'h20, 0);

        // Concurrent write+read of reg3 with responses stalled for 5 cycles.
        exp_r = mdl[3];
        d = $urandom;
        bus.s00_axi_awaddr = 6'hC; bus.s00_axi_wdata = d; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_araddr = 6'hC;
        bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1; bus.s00_axi_arvalid = 1'b1;
        @(negedge clk);
        check("stall_readys_idle",
              {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 3'b111);
        @(posedge clk); #1;
        bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0; bus.s00_axi_arvalid = 1'b0;
        model_write(6'hC, d, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valids", {bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 2'b11);
            check("stall_rdata_prewrite", bus.s00_axi_rdata, exp_r);
            check("stall_resps", {bus.s00_axi_bresp, bus.s00_axi_rresp}, 4'b0000);
            check("stall_readys_low",
                  {bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready}, 3'b000);
            check("stall_reg_out", reg_out, mdl_vec());
            @(posedge clk); #1;
        end
        bus.s00_axi_bready = 1'b1; bus.s00_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s00_axi_bready = 1'b0; bus.s00_axi_rready = 1'b0;
        @(negedge clk);
        check("stall_released", {bus.s00_axi_bvalid, bus.s00_axi_rvalid, bus.s00_axi_arready}, 3'b001);
        @(posedge clk); #1;

        // Reset in the middle of a write holding only its address.
        do_reset();
        bus.s00_axi_awaddr = 6'h4; bus.s00_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.s00_axi_awvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.s00_axi_wdata = 32'h55; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_wvalid = 1'b1; bus.s00_axi_bready = 1'b1;
        @(negedge clk);
        check("abandon_wready", bus.s00_axi_wready, 1);
        @(posedge clk); #1;
        bus.s00_axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abandon_no_bvalid", bus.s00_axi_bvalid, 0);
            check("abandon_reg1", reg_out[63:32], 32'h0);
            @(posedge clk); #1;
        end
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[5:4] = 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                axi_read(a, $urandom_range(0, 3));
            end
        end
        check("final_reg_out", reg_out, mdl_vec());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
